// File: rtl/jcpu_step_pkg.sv
// Shared definitions for the step interface: step count, error bit indices,
// monitor state encoding and one-hot helpers.
package jcpu_step_pkg;

  localparam int unsigned STEP_COUNT = 6;
  localparam int unsigned ERR_W      = 3;
  localparam int unsigned ERR_ONEHOT = 0;
  localparam int unsigned ERR_ORDER  = 1;
  localparam int unsigned ERR_PHASE  = 2;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SYNC   = 2'd1,
    FAULT  = 2'd2
  } step_state_e;

  // True when exactly one bit is set (zero is not one-hot).
  function automatic logic is_onehot(input logic [STEP_COUNT-1:0] v);
    return (v != '0) && ((v & (v - STEP_COUNT'(1))) == '0);
  endfunction

  // Successor of a step vector, bit i = step i; the last step wraps to step 0.
  function automatic logic [STEP_COUNT-1:0] rot_next(input logic [STEP_COUNT-1:0] v);
    return {v[STEP_COUNT-2:0], v[STEP_COUNT-1]};
  endfunction

endpackage

// File: rtl/jedge_det.sv
// 1-bit input register plus rise/fall detector.
// Ports: clk, reset (async active-low), d (raw input),
//        q (registered input), rise_c / fall_c (q vs its previous value).
module jedge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic q_prev;

  // Two-stage sample: q is the current value, q_prev the one before it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= 1'b0;
      q_prev <= 1'b0;
    end else begin
      q      <= d;
      q_prev <= q;
    end
  end

  assign rise_c = q & ~q_prev;
  assign fall_c = ~q & q_prev;

endmodule

// File: rtl/jstep_monitor.sv
// Receive-side checker for the clock-phase/stepper interface. Rebuilds the
// step index from the one-hot step bus, emits enable-rise / set-fall strobes,
// counts completed instructions and latches protocol errors.
// Ports:
//   clk, reset (async active-low), clr (sync fault clear)
//   wclke, wclks          phase strobes
//   bos[0:5]              one-hot step bus, bos[0] is the first step
//   sync, fault           state indications
//   step_idx              current step while sync
//   en_rise, set_fall     one-cycle strobes while sync
//   instr_cnt             completed instruction count (wraps)
//   err                   sticky {phase, order, one-hot} flags
module jstep_monitor
  import jcpu_step_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter bit          REQ_SET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wclke,
  input  logic             wclks,
  input  logic [0:5]       bos,
  output logic             sync,
  output logic [2:0]       step_idx,
  output logic             en_rise,
  output logic             set_fall,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [ERR_W-1:0] err,
  output logic             fault
);

  localparam int unsigned SW = STEP_COUNT;
  localparam logic [SW-1:0] STEP0 = SW'(1);
  localparam logic [2:0] LAST_IDX = 3'(SW - 1);

  step_state_e state;

  logic [SW-1:0] bos_v;
  logic [SW-1:0] bos_q1;
  logic [SW-1:0] bos_q2;

  logic en_q;
  logic en_rise_c;
  logic en_fall_unused;
  logic s_q;
  logic s_rise_c;
  logic s_fall_c;

  logic [1:0]       set_cnt;
  logic             bos_chg;
  logic [ERR_W-1:0] err_set;
  logic             go_fault;

  // Re-index the bus so bit i of the vector is step i.
  always_comb begin
    bos_v = '0;
    for (int i = 0; i < SW; i++) begin
      bos_v[i] = bos[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bos_q1 <= '0;
      bos_q2 <= '0;
    end else begin
      bos_q1 <= bos_v;
      bos_q2 <= bos_q1;
    end
  end

  jedge_det u_en (
    .clk    (clk),
    .reset  (reset),
    .d      (wclke),
    .q      (en_q),
    .rise_c (en_rise_c),
    .fall_c (en_fall_unused)
  );

  jedge_det u_set (
    .clk    (clk),
    .reset  (reset),
    .d      (wclks),
    .q      (s_q),
    .rise_c (s_rise_c),
    .fall_c (s_fall_c)
  );

  // Error conditions evaluated every cycle; only acted on in SYNC.
  // A set rise coinciding with a step change belongs to the new step, so it
  // can never be a duplicate.
  always_comb begin
    err_set  = '0;
    bos_chg  = (bos_q1 != bos_q2);
    err_set[ERR_ONEHOT] = bos_chg && !is_onehot(bos_q1);
    err_set[ERR_ORDER]  = bos_chg && is_onehot(bos_q1) && (bos_q1 != rot_next(bos_q2));
    err_set[ERR_PHASE]  = (s_q && !en_q)
                       || (s_rise_c && !bos_chg && (set_cnt != 2'd0))
                       || (bos_chg && REQ_SET && (set_cnt != 2'd1));
    go_fault = |err_set;
  end

  // Monitor FSM with step tracking, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= UNSYNC;
      sync      <= 1'b0;
      fault     <= 1'b0;
      step_idx  <= '0;
      set_cnt   <= '0;
      instr_cnt <= '0;
      err       <= '0;
      en_rise   <= 1'b0;
      set_fall  <= 1'b0;
    end else begin
      en_rise  <= 1'b0;
      set_fall <= 1'b0;
      unique case (state)
        UNSYNC: begin
          if (bos_q1 == STEP0) begin
            state    <= SYNC;
            sync     <= 1'b1;
            step_idx <= '0;
            set_cnt  <= '0;
          end
        end
        SYNC: begin
          if (go_fault) begin
            state <= FAULT;
            sync  <= 1'b0;
            fault <= 1'b1;
            err   <= err | err_set;
          end else begin
            en_rise  <= en_rise_c;
            set_fall <= s_fall_c;
            if (bos_chg) begin
              if (step_idx == LAST_IDX) begin
                step_idx  <= '0;
                instr_cnt <= instr_cnt + CNT_W'(1);
              end else begin
                step_idx <= step_idx + 3'd1;
              end
              set_cnt <= s_rise_c ? 2'd1 : 2'd0;
            end else if (s_rise_c) begin
              set_cnt <= set_cnt + 2'd1;
            end
          end
        end
        FAULT: begin
          if (clr) begin
            state     <= UNSYNC;
            fault     <= 1'b0;
            err       <= '0;
            instr_cnt <= '0;
          end
        end
        default: begin
          state <= UNSYNC;
          sync  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule
